// File: rtl/motion_driver_pkg.sv
// Shared types and default timing constants for the motion driver.
package motion_driver_pkg;

  typedef enum logic [1:0] {
    AX_IDLE,
    AX_SETUP,
    AX_HIGH,
    AX_LOW
  } axis_state_e;

  localparam int DEF_DIR_SETUP_CYCLES = 50;
  localparam int DEF_SERVO_PERIOD     = 1000000;
  localparam int DEF_MIN_HALF         = 2;

  function automatic logic [31:0] clamp_half(
    input logic [31:0] speed,
    input logic [31:0] min_half
  );
    return (speed < min_half) ? min_half : speed;
  endfunction

endpackage

// File: rtl/step_axis.sv
// One step/dir axis: IDLE/SETUP/HIGH/LOW pulse FSM with a signed
// position counter that moves on every rising step edge.
module step_axis
  import motion_driver_pkg::*;
#(
  parameter int DIR_SETUP_CYCLES = DEF_DIR_SETUP_CYCLES,
  parameter int MIN_HALF         = DEF_MIN_HALF
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        dir_bit,
  input  logic [31:0] speed,
  input  logic        zero_pos,
  output logic        step,
  output logic        dir,
  output logic [31:0] pos,
  output logic        busy
);

  localparam logic [31:0] SETUP_LAST =
    32'(DIR_SETUP_CYCLES) - 32'd1;
  localparam logic [31:0] MIN_HALF_W = 32'(MIN_HALF);

  axis_state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] half_q, half_d;
  logic        step_q, step_d;
  logic        dir_q, dir_d;
  logic [31:0] pos_q, pos_d;

  logic        start;
  logic        done;
  logic        launch;
  logic [31:0] half_new;

  assign start    = (speed != 32'd0);
  assign done     = (cnt_q == 32'd0);
  assign half_new = clamp_half(speed, MIN_HALF_W);

  // A new period may only begin from IDLE or the last LOW cycle.
  assign launch = start &&
    ((state_q == AX_IDLE) ||
     ((state_q == AX_LOW) && done));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    step_d  = step_q;
    dir_d   = dir_q;
    pos_d   = pos_q;

    unique case (state_q)
      AX_IDLE: begin
        step_d = 1'b0;
      end
      AX_SETUP: begin
        if (done) begin
          state_d = AX_HIGH;
          step_d  = 1'b1;
          cnt_d   = half_q - 32'd1;
          pos_d   = dir_q ? pos_q + 32'd1
                          : pos_q - 32'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      AX_HIGH: begin
        if (done) begin
          state_d = AX_LOW;
          step_d  = 1'b0;
          cnt_d   = half_q - 32'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      AX_LOW: begin
        if (done) begin
          state_d = AX_IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
    endcase

    if (launch) begin
      half_d = half_new;
      if (dir_bit != dir_q) begin
        state_d = AX_SETUP;
        dir_d   = dir_bit;
        step_d  = 1'b0;
        cnt_d   = SETUP_LAST;
      end else begin
        state_d = AX_HIGH;
        step_d  = 1'b1;
        cnt_d   = half_new - 32'd1;
        pos_d   = dir_q ? pos_q + 32'd1
                        : pos_q - 32'd1;
      end
    end

    if (zero_pos) begin
      pos_d = 32'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      state_q <= AX_IDLE;
      cnt_q   <= 32'd0;
      half_q  <= 32'd0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      pos_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
    end
  end

  assign step = step_q;
  assign dir  = dir_q;
  assign pos  = pos_q;
  assign busy = (state_q != AX_IDLE);

endmodule

// File: rtl/motion_driver.sv
// Two independent step/dir axes plus a free-running servo PWM
// whose duty is captured once per period.
module motion_driver
  import motion_driver_pkg::*;
#(
  parameter int DIR_SETUP_CYCLES = DEF_DIR_SETUP_CYCLES,
  parameter int SERVO_PERIOD     = DEF_SERVO_PERIOD,
  parameter int MIN_HALF         = DEF_MIN_HALF
) (
  input  logic               clock,
  input  logic               ctrl_reset,
  input  logic [31:0]        step_x_dir,
  input  logic [31:0]        step_y_dir,
  input  logic [31:0]        step_x_speed,
  input  logic [31:0]        step_y_speed,
  input  logic [31:0]        servo_duty_cycle,
  input  logic               zero_pos,
  output logic               x_step,
  output logic               y_step,
  output logic               x_dir,
  output logic               y_dir,
  output logic signed [31:0] x_pos,
  output logic signed [31:0] y_pos,
  output logic               x_busy,
  output logic               y_busy,
  output logic               servo_pwm
);

  localparam logic [31:0] SERVO_LAST =
    32'(SERVO_PERIOD) - 32'd1;

  logic        unused_dir_bits;
  logic [31:0] x_pos_w, y_pos_w;

  assign unused_dir_bits =
    ^{step_x_dir[31:1], step_y_dir[31:1]};

  step_axis #(
    .DIR_SETUP_CYCLES(DIR_SETUP_CYCLES),
    .MIN_HALF        (MIN_HALF)
  ) u_x (
    .clock     (clock),
    .ctrl_reset(ctrl_reset),
    .dir_bit   (step_x_dir[0]),
    .speed     (step_x_speed),
    .zero_pos  (zero_pos),
    .step      (x_step),
    .dir       (x_dir),
    .pos       (x_pos_w),
    .busy      (x_busy)
  );

  step_axis #(
    .DIR_SETUP_CYCLES(DIR_SETUP_CYCLES),
    .MIN_HALF        (MIN_HALF)
  ) u_y (
    .clock     (clock),
    .ctrl_reset(ctrl_reset),
    .dir_bit   (step_y_dir[0]),
    .speed     (step_y_speed),
    .zero_pos  (zero_pos),
    .step      (y_step),
    .dir       (y_dir),
    .pos       (y_pos_w),
    .busy      (y_busy)
  );

  assign x_pos = x_pos_w;
  assign y_pos = y_pos_w;

  logic [31:0] servo_cnt_q, servo_cnt_d;
  logic [31:0] duty_q, duty_d;
  logic        pwm_q, pwm_d;

  // The duty sampled at count 0 already governs that same cycle.
  always_comb begin
    servo_cnt_d = (servo_cnt_q == SERVO_LAST)
                ? 32'd0 : servo_cnt_q + 32'd1;
    duty_d      = (servo_cnt_q == 32'd0)
                ? servo_duty_cycle : duty_q;
    pwm_d       = (servo_cnt_q < duty_d);
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      servo_cnt_q <= 32'd0;
      duty_q      <= 32'd0;
      pwm_q       <= 1'b0;
    end else begin
      servo_cnt_q <= servo_cnt_d;
      duty_q      <= duty_d;
      pwm_q       <= pwm_d;
    end
  end

  assign servo_pwm = pwm_q;

endmodule

// File: tb/tb_motion_driver.sv
// Directed bench for motion_driver with small timing parameters.
module tb_motion_driver;

  logic               clock = 1'b0;
  logic               ctrl_reset;
  logic [31:0]        step_x_dir, step_y_dir;
  logic [31:0]        step_x_speed, step_y_speed;
  logic [31:0]        servo_duty_cycle;
  logic               zero_pos;
  logic               x_step, y_step, x_dir, y_dir;
  logic signed [31:0] x_pos, y_pos;
  logic               x_busy, y_busy, servo_pwm;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  motion_driver #(
    .DIR_SETUP_CYCLES(4),
    .SERVO_PERIOD    (100),
    .MIN_HALF        (2)
  ) dut (
    .clock           (clock),
    .ctrl_reset      (ctrl_reset),
    .step_x_dir      (step_x_dir),
    .step_y_dir      (step_y_dir),
    .step_x_speed    (step_x_speed),
    .step_y_speed    (step_y_speed),
    .servo_duty_cycle(servo_duty_cycle),
    .zero_pos        (zero_pos),
    .x_step          (x_step),
    .y_step          (y_step),
    .x_dir           (x_dir),
    .y_dir           (y_dir),
    .x_pos           (x_pos),
    .y_pos           (y_pos),
    .x_busy          (x_busy),
    .y_busy          (y_busy),
    .servo_pwm       (servo_pwm)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b0;
    step_x_dir = 0; step_y_dir = 0;
    step_x_speed = 0; step_y_speed = 0;
    servo_duty_cycle = 0; zero_pos = 0;
    repeat (3) tick();
    checks++;
    if ({x_step, y_step, x_dir, y_dir} !== 4'b0) begin
      errors++;
      $display("FAIL reset_pins got %b want 0000",
               {x_step, y_step, x_dir, y_dir});
    end
    checks++;
    if (x_pos !== 0 || y_pos !== 0) begin
      errors++;
      $display("FAIL reset_pos got %0d/%0d want 0/0", x_pos, y_pos);
    end
    checks++;
    if ({x_busy, y_busy, servo_pwm} !== 3'b0) begin
      errors++;
      $display("FAIL reset_busy_pwm got %b want 000",
               {x_busy, y_busy, servo_pwm});
    end
    ctrl_reset = 1'b1;
  endtask

  // dir differs from the reset value 0, so a SETUP phase precedes the pulse
  task automatic test_first_setup();
    logic es, eb;
    step_x_dir = 1; step_x_speed = 5;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 1) begin
        step_x_speed = 0;
        checks++;
        if (x_dir !== 1'b1) begin
          errors++;
          $display("FAIL setup_dir got %b want 1", x_dir);
        end
      end
      es = (k >= 5 && k <= 9);
      eb = (k <= 14);
      checks++;
      if (x_step !== es || x_busy !== eb) begin
        errors++;
        $display("FAIL setup_seq k=%0d got %b%b want %b%b",
                 k, x_step, x_busy, es, eb);
      end
      if (k == 5) begin
        checks++;
        if (x_pos !== 1) begin
          errors++;
          $display("FAIL setup_pos got %0d want 1", x_pos);
        end
      end
    end
    checks++;
    if (y_busy !== 1'b0 || y_step !== 1'b0) begin
      errors++;
      $display("FAIL setup_y_idle got %b%b want 00", y_busy, y_step);
    end
  endtask

  task automatic test_zero_idle();
    zero_pos = 1;
    tick();
    zero_pos = 0;
    checks++;
    if (x_pos !== 0 || y_pos !== 0) begin
      errors++;
      $display("FAIL zero_idle got %0d/%0d want 0/0", x_pos, y_pos);
    end
  endtask

  // x_dir already 1: rise on the edge right after the decision cycle
  task automatic test_run();
    logic es;
    step_x_speed = 5;
    for (int k = 1; k <= 23; k++) begin
      tick();
      es = (((k - 1) / 5) % 2) == 0;
      checks++;
      if (x_step !== es || y_step !== 1'b0) begin
        errors++;
        $display("FAIL run_step k=%0d got %b%b want %b0",
                 k, x_step, y_step, es);
      end
    end
    checks++;
    if (x_pos !== 3 || x_dir !== 1'b1) begin
      errors++;
      $display("FAIL run_pos got %0d dir %b want 3 dir 1",
               x_pos, x_dir);
    end
  endtask

  task automatic test_dir_change();
    logic es;
    step_x_dir = 0;
    for (int k = 24; k <= 35; k++) begin
      tick();
      es = (k <= 25) || (k == 35);
      checks++;
      if (x_step !== es) begin
        errors++;
        $display("FAIL dirchg_step k=%0d got %b want %b",
                 k, x_step, es);
      end
      if (k == 25 || k == 31) begin
        checks++;
        if (x_dir !== (k == 25)) begin
          errors++;
          $display("FAIL dirchg_dir k=%0d got %b want %b",
                   k, x_dir, (k == 25));
        end
      end
    end
    checks++;
    if (x_pos !== 2) begin
      errors++;
      $display("FAIL dirchg_pos got %0d want 2", x_pos);
    end
  endtask

  task automatic test_stop_and_min_half();
    logic es, eb;
    bit   idle;
    step_x_speed = 0;
    for (int k = 36; k <= 55; k++) begin
      tick();
      es = (k <= 39);
      eb = (k <= 44);
      checks++;
      if (x_step !== es || x_busy !== eb) begin
        errors++;
        $display("FAIL stop_seq k=%0d got %b%b want %b%b",
                 k, x_step, x_busy, es, eb);
      end
    end
    step_x_speed = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      es = (((k - 1) / 2) % 2) == 0;
      checks++;
      if (x_step !== es) begin
        errors++;
        $display("FAIL minhalf_step k=%0d got %b want %b",
                 k, x_step, es);
      end
    end
    checks++;
    if (x_pos !== 0) begin
      errors++;
      $display("FAIL minhalf_pos got %0d want 0", x_pos);
    end
    step_x_speed = 0;
    idle = 0;
    for (int i = 0; i < 20 && !idle; i++) begin
      tick();
      idle = (x_busy == 1'b0);
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL minhalf_idle got busy 1 want 0");
    end
  endtask

  task automatic test_zero_same_cycle();
    bit idle;
    step_x_dir = 1; step_x_speed = 2;
    for (int k = 1; k <= 37; k++) begin
      tick();
      if (k == 29) begin
        checks++;
        if (x_pos !== 7) begin
          errors++;
          $display("FAIL zsc_pre got %0d want 7", x_pos);
        end
      end
      if (k == 32) zero_pos = 1;
      if (k == 33) begin
        zero_pos = 0;
        checks++;
        if (x_pos !== 0 || x_step !== 1'b1) begin
          errors++;
          $display("FAIL zsc_zero got %0d step %b want 0 step 1",
                   x_pos, x_step);
        end
      end
    end
    checks++;
    if (x_pos !== 1) begin
      errors++;
      $display("FAIL zsc_after got %0d want 1", x_pos);
    end
    step_x_speed = 0;
    idle = 0;
    for (int i = 0; i < 20 && !idle; i++) begin
      tick();
      idle = (x_busy == 1'b0);
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL zsc_idle got busy 1 want 0");
    end
  endtask

  task automatic servo_period(output int highs);
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (servo_pwm === 1'b1) highs++;
    end
  endtask

  task automatic test_servo();
    bit found;
    int highs, lows;
    servo_duty_cycle = 30;
    found = 0;
    for (int i = 0; i < 250 && !found; i++) begin
      tick();
      found = (servo_pwm === 1'b1);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL servo_rise got none want rise");
    end
    highs = 1; lows = 0;
    for (int i = 1; i < 100; i++) begin
      if (i == 50) servo_duty_cycle = 60;
      tick();
      if (servo_pwm === 1'b1) highs++;
      else lows++;
    end
    checks++;
    if (highs !== 30 || lows !== 70) begin
      errors++;
      $display("FAIL servo_30 got %0d/%0d want 30/70", highs, lows);
    end
    servo_period(highs);
    checks++;
    if (highs !== 60) begin
      errors++;
      $display("FAIL servo_60 got %0d want 60", highs);
    end
    servo_duty_cycle = 150;
    servo_period(highs);
    checks++;
    if (highs !== 100) begin
      errors++;
      $display("FAIL servo_150 got %0d want 100", highs);
    end
    servo_duty_cycle = 0;
    servo_period(highs);
    checks++;
    if (highs !== 0) begin
      errors++;
      $display("FAIL servo_0 got %0d want 0", highs);
    end
    servo_duty_cycle = 150;
    servo_period(highs);
  endtask

  task automatic test_reset_mid_pulse();
    step_y_dir = 0; step_y_speed = 3;
    step_x_dir = 1; step_x_speed = 3;
    repeat (8) tick();
    checks++;
    if (y_pos !== -32'sd2 || y_step !== 1'b1) begin
      errors++;
      $display("FAIL both_y got %0d step %b want -2 step 1",
               y_pos, y_step);
    end
    checks++;
    if (x_pos !== 3 || x_step !== 1'b1 || servo_pwm !== 1'b1) begin
      errors++;
      $display("FAIL both_x got %0d %b%b want 3 11",
               x_pos, x_step, servo_pwm);
    end
    ctrl_reset = 0;
    tick();
    checks++;
    if ({y_step, y_busy, servo_pwm, x_step} !== 4'b0 ||
        y_pos !== 0 || x_pos !== 0) begin
      errors++;
      $display("FAIL midreset got %b %0d %0d want 0000 0 0",
               {y_step, y_busy, servo_pwm, x_step}, y_pos, x_pos);
    end
    step_y_speed = 0;
    step_x_dir = 0; step_x_speed = 2;
    ctrl_reset = 1;
    tick();
    checks++;
    if (x_step !== 1'b1 || x_dir !== 1'b0 || x_pos !== -32'sd1) begin
      errors++;
      $display("FAIL post_reset got %b%b %0d want 10 -1",
               x_step, x_dir, x_pos);
    end
    step_x_speed = 0;
  endtask

  initial begin
    test_reset();
    test_first_setup();
    test_zero_idle();
    test_run();
    test_dir_change();
    test_stop_and_min_half();
    test_zero_same_cycle();
    test_servo();
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
